// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// ALU control codes, data-processing commands and condition codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Unknown commands fall back to ADD so they still count as arithmetic.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: return ALU_ADD;
      CMD_SUB: return ALU_SUB;
      CMD_CMP: return ALU_SUB;
      CMD_AND: return ALU_AND;
      CMD_ORR: return ALU_ORR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cond_unit.sv
// Condition unit: holds the {N,Z,C,V} flags register and evaluates the
// instruction condition against the registered flags.
module cond_unit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  output logic       cond_ex
);

  logic [3:0] flags_q, flags_d;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // flag_w[1] enables N/Z, flag_w[0] enables C/V; both need a passing condition.
  always_comb begin
    flags_d = flags_q;
    if (flag_w[1] && cond_ex) flags_d[3:2] = alu_flags[3:2];
    if (flag_w[0] && cond_ex) flags_d[1:0] = alu_flags[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle controller: instruction FSM, datapath control decode and write
// gating. Define MC_RETIRE_CNT_EN to add the retired_cnt instruction counter.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_ready,
  input  logic [3:0]  cond,
  input  logic [1:0]  op,
  input  logic [5:0]  func,
  input  logic [3:0]  rd,
  input  logic [3:0]  ALUflags,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl
`ifdef MC_RETIRE_CNT_EN
  ,
  output logic [31:0] retired_cnt
`endif
);

  state_e     state_q, state_d;
  logic       next_pc, reg_w, mem_w, branch, alu_op;
  logic       cond_ex, pcs;
  logic [1:0] flag_w;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = func[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = func[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      // CMP only sets flags, so it skips the register writeback.
      S_EXECR, S_EXECI: state_d = (func[4:1] == CMD_CMP) ? S_FETCH : S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    next_pc   = 1'b0;
    IRWrite   = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        next_pc   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECR:  alu_op = 1'b1;
      S_EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      S_ALUWB:  reg_w = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign ALUControl = alu_op ? alu_decode(func[4:1]) : ALU_ADD;
  assign ImmSrc     = op;
  assign RegSrc     = {op == OP_MEM, op == OP_BR};

  // Logical ops (ALUControl[1]=1) leave C and V untouched.
  assign flag_w = {alu_op & func[0], alu_op & func[0] & ~ALUControl[1]};

  cond_unit u_cond_unit (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (ALUflags),
    .flag_w    (flag_w),
    .cond_ex   (cond_ex)
  );

  assign pcs      = ((rd == 4'd15) & reg_w) | branch;
  assign PCWrite  = (pcs & cond_ex) | next_pc;
  assign RegWrite = reg_w & cond_ex;
  assign MemWrite = mem_w & cond_ex;

`ifdef MC_RETIRE_CNT_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;

  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (state_d == S_FETCH && state_q != S_FETCH) retired_cnt_d = retired_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) retired_cnt_q <= 32'd0;
    else       retired_cnt_q <= retired_cnt_d;
  end

  assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: an instruction-level model
// (step lists per instruction) checked every cycle, plus directed scenarios.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset, mem_ready;
  logic [3:0] cond, rd, ALUflags;
  logic [1:0] op;
  logic [5:0] func;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
`ifdef MC_RETIRE_CNT_EN
  logic [31:0] retired_cnt;
`endif

  multicycle_controller dut (
    .clk(clk), .reset(reset), .mem_ready(mem_ready), .cond(cond), .op(op),
    .func(func), .rd(rd), .ALUflags(ALUflags),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
`ifdef MC_RETIRE_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: remaining steps of the current instruction, flags, retire count.
  string       path[$];
  logic [3:0]  m_flags;
  logic [31:0] m_retired;

  bit          ready_q[$];
  bit          dir_valid, flags_fixed, rst_req;
  logic [1:0]  d_op;
  logic [5:0]  d_func;
  logic [3:0]  d_cond, d_rd, flags_val;
  logic [31:0] tr_regw, tr_pcw, tr_memw, tr_irw;
  int          tr_n;

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_code(input logic [3:0] cmd);
    if (cmd == 4'b0000) return 2'd2;
    if (cmd == 4'b1100) return 2'd3;
    if (cmd == 4'b0010 || cmd == 4'b1010) return 2'd1;
    return 2'd0;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic buildPath();
    path.delete();
    path.push_back("FETCH");
    path.push_back("DECODE");
    case (op)
      2'b01: begin
        path.push_back("MEMADR");
        if (func[0]) begin
          path.push_back("MEMRD");
          path.push_back("MEMWB");
        end else path.push_back("MEMWR");
      end
      2'b00: begin
        path.push_back(func[5] ? "EXECI" : "EXECR");
        if (func[4:1] != 4'b1010) path.push_back("ALUWB");
      end
      2'b10: path.push_back("BRANCH");
      default: ;
    endcase
  endtask

  task automatic applyStimulus();
    logic [3:0] cmds [5];
    cmds = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100};
    reset = rst_req;
    if (path.size() == 0) begin
      if (dir_valid) begin
        op = d_op; func = d_func; cond = d_cond; rd = d_rd;
      end else begin
        op   = 2'($urandom);
        func = 6'($urandom);
        if ($urandom_range(0, 1) == 1) func[4:1] = cmds[$urandom_range(0, 4)];
        cond = ($urandom_range(0, 1) == 1) ? 4'b1110 : 4'($urandom);
        rd   = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom);
      end
      buildPath();
    end
    mem_ready = (ready_q.size() != 0) ? ready_q.pop_front() : ($urandom_range(0, 9) < 7);
    ALUflags  = flags_fixed ? flags_val : 4'($urandom);
  endtask

  task automatic checkOutput();
    string s;
    bit ce, rw, mw, br, aop, npc;
    logic [1:0] e_b, e_res;
    s   = path[0];
    ce  = cond_holds(cond, m_flags);
    npc = (s == "FETCH") && mem_ready;
    rw  = (s == "MEMWB") || (s == "ALUWB");
    mw  = (s == "MEMWR");
    br  = (s == "BRANCH");
    aop = (s == "EXECR") || (s == "EXECI");
    e_b = (s == "FETCH" || s == "DECODE") ? 2'd2 :
          (s == "MEMADR" || s == "EXECI" || s == "BRANCH") ? 2'd1 : 2'd0;
    e_res = (s == "FETCH" || s == "DECODE" || s == "BRANCH") ? 2'd2 :
            (s == "MEMWB") ? 2'd1 : 2'd0;
    cmp({"PCWrite@", s}, 32'(PCWrite), 32'(((((rd == 4'd15) && rw) || br) && ce) || npc));
    cmp({"IRWrite@", s}, 32'(IRWrite), 32'(npc));
    cmp({"MemWrite@", s}, 32'(MemWrite), 32'(mw && ce));
    cmp({"RegWrite@", s}, 32'(RegWrite), 32'(rw && ce));
    cmp({"AdrSrc@", s}, 32'(AdrSrc), 32'(s == "MEMRD" || s == "MEMWR"));
    cmp({"ALUSrcA@", s}, 32'(ALUSrcA), 32'(s == "FETCH" || s == "DECODE"));
    cmp({"ALUSrcB@", s}, 32'(ALUSrcB), 32'(e_b));
    cmp({"ResultSrc@", s}, 32'(ResultSrc), 32'(e_res));
    cmp({"ImmSrc@", s}, 32'(ImmSrc), 32'(op));
    cmp({"RegSrc@", s}, 32'(RegSrc), 32'({op == 2'b01, op == 2'b10}));
    cmp({"ALUControl@", s}, 32'(ALUControl), 32'(aop ? alu_code(func[4:1]) : 2'd0));
`ifdef MC_RETIRE_CNT_EN
    cmp({"retired_cnt@", s}, retired_cnt, m_retired);
`endif
    if (tr_n < 32) begin
      tr_regw[tr_n] = RegWrite;
      tr_pcw[tr_n]  = PCWrite;
      tr_memw[tr_n] = MemWrite;
      tr_irw[tr_n]  = IRWrite;
    end
    tr_n++;
  endtask

  task automatic modelStep();
    string s;
    bit ce;
    if (reset) begin
      path.delete();
      m_flags   = 4'b0000;
      m_retired = 32'd0;
      return;
    end
    s  = path[0];
    ce = cond_holds(cond, m_flags);
    if ((s == "EXECR" || s == "EXECI") && func[0] && ce) begin
      m_flags[3:2] = ALUflags[3:2];
      if (func[4:1] != 4'b0000 && func[4:1] != 4'b1100) m_flags[1:0] = ALUflags[1:0];
    end
    if (!((s == "FETCH" || s == "MEMRD" || s == "MEMWR") && !mem_ready)) begin
      void'(path.pop_front());
      if (path.size() == 0) m_retired++;
    end
  endtask

  task automatic doCycle();
    applyStimulus();
    #2;
    checkOutput();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic clearTrace();
    tr_regw = '0; tr_pcw = '0; tr_memw = '0; tr_irw = '0; tr_n = 0;
  endtask

  task automatic runInstr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] c,
                          input logic [3:0] r, output int n);
    d_op = o; d_func = f; d_cond = c; d_rd = r;
    dir_valid = 1'b1;
    clearTrace();
    n = 0;
    do begin
      doCycle();
      n++;
    end while (path.size() != 0 && n < 60);
    if (path.size() != 0) cmp("instr_timeout", 32'(path.size()), 32'd0);
    dir_valid = 1'b0;
    ready_q.delete();
  endtask

  initial begin
    int n;
    reset = 1'b1; mem_ready = 1'b0; cond = 4'd0; op = 2'd0; func = 6'd0; rd = 4'd0;
    ALUflags = 4'd0; rst_req = 1'b0; dir_valid = 1'b0; flags_fixed = 1'b1; flags_val = 4'd0;
    m_flags = 4'd0; m_retired = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    // ADD immediate: FETCH, DECODE, EXECI, ALUWB.
    ready_q = '{1'b1, 1'b1, 1'b1, 1'b1};
    runInstr(2'b00, 6'b001000, 4'b1110, 4'd1, n);
    cmp("add_cycles", 32'(n), 32'd4);
    cmp("add_regwrite", tr_regw, 32'h8);
    cmp("reset_state_irwrite", tr_irw, 32'h1);
    cmp("reset_state_pcwrite", tr_pcw, 32'h1);

    // LDR with three wait cycles in MEMRD.
    ready_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    runInstr(2'b01, 6'b011001, 4'b1110, 4'd2, n);
    cmp("ldr_cycles", 32'(n), 32'd8);
    cmp("ldr_regwrite", tr_regw, 32'h80);

    // SUBS with a zero result, then BEQ taken and BNE not taken.
    flags_val = 4'b0100;
    ready_q = '{1'b1};
    runInstr(2'b00, 6'b000101, 4'b1110, 4'd3, n);
    cmp("subs_regwrite", tr_regw, 32'h8);
    ready_q = '{1'b1};
    runInstr(2'b10, 6'b000000, 4'b0000, 4'd0, n);
    cmp("beq_cycles", 32'(n), 32'd3);
    cmp("beq_pcwrite", tr_pcw, 32'h5);
    ready_q = '{1'b1};
    runInstr(2'b10, 6'b000000, 4'b0001, 4'd0, n);
    cmp("bne_pcwrite", tr_pcw, 32'h1);

    // CMP producing N: no writeback, then BMI taken.
    flags_val = 4'b1000;
    ready_q = '{1'b1};
    runInstr(2'b00, 6'b010101, 4'b1110, 4'd4, n);
    cmp("cmp_cycles", 32'(n), 32'd3);
    cmp("cmp_regwrite", tr_regw, 32'h0);
    ready_q = '{1'b1};
    runInstr(2'b10, 6'b000000, 4'b0100, 4'd0, n);
    cmp("bmi_pcwrite", tr_pcw, 32'h5);

    // STR with cond=1111 never writes memory.
    ready_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    runInstr(2'b01, 6'b011000, 4'b1111, 4'd5, n);
    cmp("str_nv_cycles", 32'(n), 32'd6);
    cmp("str_nv_memwrite", tr_memw, 32'h0);

    // Set Z, start an STR, reset it while stalled in MEMWR.
    flags_val = 4'b0100;
    ready_q = '{1'b1};
    runInstr(2'b00, 6'b000101, 4'b1110, 4'd3, n);
    d_op = 2'b01; d_func = 6'b011000; d_cond = 4'b1110; d_rd = 4'd6;
    dir_valid = 1'b1;
    clearTrace();
    ready_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    repeat (4) doCycle();
    cmp("str_memwrite_before_reset", tr_memw, 32'h8);
    rst_req = 1'b1;
    doCycle();
    rst_req = 1'b0;
    ready_q.delete();
`ifdef MC_RETIRE_CNT_EN
    cmp("retired_after_reset", retired_cnt, 32'd0);
`endif
    ready_q = '{1'b1, 1'b1, 1'b1};
    runInstr(2'b10, 6'b000000, 4'b0001, 4'd0, n);
    cmp("after_reset_memwrite", tr_memw, 32'h0);
    cmp("after_reset_irwrite", tr_irw, 32'h1);
    cmp("after_reset_bne_pcwrite", tr_pcw, 32'h5);

    // Randomized traffic with occasional mid-instruction resets.
    flags_fixed = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst_req = ($urandom_range(0, 49) == 0);
      doCycle();
    end
    rst_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk sampled on the rising edge, reset synchronous active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 mem_ready  in  1  memory done; qualifies the FETCH, MEMRD and MEMWR states.
REQ-005 cond  in  4  instruction condition field, taken from the stable instruction register.
REQ-006 op  in  2  instruction class: 00 data-processing, 01 memory, 10 branch.
REQ-007 func  in  6  funct field; [5] immediate, [4:1] cmd, [0] S/L.
REQ-008 rd  in  4  destination register.
REQ-009 ALUflags  in  4  ALU result flags {N,Z,C,V}.
REQ-010 PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA  out  1 each  datapath strobes and selects.
REQ-011 ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl  out  2 each  datapath selects.

Function
REQ-012 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB and BRANCH.
REQ-013 FETCH SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-014 DECODE SHALL go to: op=01 -> MEMADR; op=00 with func[5]=0 -> EXECR; op=00 with func[5]=1 -> EXECI; op=10 -> BRANCH; op=11 -> FETCH with no side effects.
REQ-015 MEMADR SHALL go to MEMRD if func[0]=1, else MEMWR.
REQ-016 MEMRD SHALL hold until mem_ready=1, then go to MEMWB; MEMWB SHALL go to FETCH.
REQ-017 MEMWR SHALL hold until mem_ready=1, then go to FETCH.
REQ-018 EXECR and EXECI SHALL go to ALUWB, except CMP (func[4:1]=1010), which SHALL go to FETCH.
REQ-019 ALUWB and BRANCH SHALL go to FETCH.
REQ-020 Raw controls per state (unlisted = 0):
- FETCH: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; IRWrite and NextPC only in the cycle mem_ready=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1 until mem_ready=1.
- EXECR: ALUOp=1.
- EXECI: ALUSrcB=01, ALUOp=1.
- ALUWB: RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-021 ALUControl SHALL be 00 when ALUOp=0. When ALUOp=1 it SHALL decode func[4:1]: 0100 -> 00, 0010 -> 01, 1010 -> 01, 0000 -> 10, 1100 -> 11, any other value -> 00.
REQ-022 ImmSrc SHALL equal op.
REQ-023 RegSrc SHALL be {op==01, op==10}.
REQ-024 CondEx SHALL be evaluated on the registered flags for EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE and AL (1110); cond=1111 SHALL give CondEx=0.
REQ-025 PCS SHALL be (rd==15 and RegW) or Branch.
REQ-026 PCWrite SHALL be (PCS and CondEx) or NextPC.
REQ-027 RegWrite SHALL be RegW and CondEx.
REQ-028 MemWrite SHALL be MemW and CondEx.
REQ-029 Flags register update, only in EXECR/EXECI with func[0]=1 and CondEx=1:
- N and Z SHALL load from ALUflags.
- C and V SHALL load only when ALUControl[1]=0 (arithmetic ops).
REQ-030 A failed condition SHALL still traverse the full state path with all writes suppressed.

Reset
REQ-031 While reset=1 on a clk edge, state SHALL become FETCH and the flags register SHALL become 0000.
REQ-032 Reset mid-instruction (for example in MEMWR while mem_ready=0) SHALL abort the access; MemWrite SHALL be 0 from the next cycle.
REQ-033 Reset value of every output SHALL be the FETCH combination with mem_ready as applied.

Configuration
REQ-034 Macro MC_RETIRE_CNT_EN defined SHALL add output retired_cnt (out, 32 bits). It SHALL reset to 0 and increment by 1, wrapping, on every transition into FETCH from a state other than FETCH or reset.
REQ-035 With MC_RETIRE_CNT_EN undefined, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-036 Package mc_pkg SHALL hold:
- the state enum (4 bits);
- the ALUControl codes;
- the cond codes;
- the CMD_CMP constant (1010).
REQ-037 Sub-module cond_unit SHALL contain the flags register and the CondEx logic; the FSM and decode logic SHALL stay in multicycle_controller.

Verification
REQ-038 ADD r1 (op=00, func=001000, cond=1110), mem_ready=1 -> FETCH, DECODE, EXECI, ALUWB; RegWrite=1 only in ALUWB; 4 cycles total.
REQ-039 LDR (op=01, func=011001), mem_ready low 3 cycles in MEMRD -> held in MEMRD 3 extra cycles; RegWrite=1 in MEMWB.
REQ-040 SUBS giving zero result (ALUflags=0100), then BEQ (op=10, cond=0000) -> PCWrite=1 in BRANCH; BNE instead -> PCWrite=0.
REQ-041 CMP (func=010101) -> EXECR then FETCH; RegWrite never 1; flags updated.
REQ-042 STR with cond=1111 -> MemWrite=0 throughout MEMWR.
REQ-043 Reset asserted in MEMWR with mem_ready=0 -> next state FETCH, MemWrite=0, flags=0000; with MC_RETIRE_CNT_EN, retired_cnt=0.
